// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit 7-segment scan controller.
// Holds the default geometry, the scan-index width and the frame record
// used by both the staging and display buffers.
package seg7_pkg;

    localparam int SEG7_DIGITS   = 8;
    localparam int SEG7_SCAN_DIV = 17;
    localparam int IDX_W         = 3;

    // One complete display image: nibbles, decimal points and blank flags.
    // Nibble k lives at data[4k+3:4k]; digit 0 is the rightmost digit.
    typedef struct packed {
        logic [4*SEG7_DIGITS-1:0] data;
        logic [SEG7_DIGITS-1:0]   point;
        logic [SEG7_DIGITS-1:0]   le;
    } seg7_frame_t;

    // Active-low one-cold digit enable for a given scan slot.
    function automatic logic [SEG7_DIGITS-1:0] seg7_onecold(input logic [IDX_W-1:0] idx);
        return ~(SEG7_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg7_lzb_mask.sv
// Leading-zero blank mask for the scan controller.
// Only present when LEADING_ZERO_BLANK_EN is defined; the default build has
// no leading-zero logic at all.
// lz[k] is set when nibbles k..DIGITS-1 are all zero and k is not digit 0,
// so an all-zero value still shows a single "0".
`ifdef LEADING_ZERO_BLANK_EN
module seg7_lzb_mask
    import seg7_pkg::*;
#(
    parameter int DIGITS = SEG7_DIGITS
) (
    input  logic [4*DIGITS-1:0] data,
    output logic [DIGITS-1:0]   lz
);

    logic zero_above;

    // Walk from the most significant digit down, tracking an unbroken run of zeros.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (data[4*k +: 4] == 4'h0);
            lz[k]      = zero_above & (k != 0);
        end
    end

endmodule
`endif

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// Presents one nibble / point / blank flag per scan slot to the downstream
// hex decoder and drives the active-low one-cold digit enables.
// Display data is double-buffered: a load lands in staging and is committed
// to the display buffer only at the frame boundary (tick in the last slot).
// A load coinciding with that boundary goes straight into the display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// The buffer record is sized from seg7_pkg, so DIGITS is expected to stay at
// SEG7_DIGITS.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS   = SEG7_DIGITS,
    parameter int SCAN_DIV = SEG7_SCAN_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   point_in,
    input  logic [DIGITS-1:0]   le_in,
    output logic [3:0]          hex,
    output logic                point,
    output logic                le,
    output logic [DIGITS-1:0]   an,
    output logic [IDX_W-1:0]    digit_idx,
    output logic                frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [SCAN_DIV-1:0] prescaler;
    logic                tick;
    logic                commit;

    seg7_frame_t         in_frame;
    seg7_frame_t         staging;
    seg7_frame_t         display;
    logic                pending;

    logic [3:0]          hex_nxt;
    logic                point_nxt;
    logic                le_nxt;
    logic [DIGITS-1:0]   an_nxt;

    assign tick     = &prescaler;
    assign commit   = tick && (digit_idx == LAST_IDX);
    assign in_frame = '{data: data_in, point: point_in, le: le_in};

    // Free-running prescaler and scan slot counter; slot advances on every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (tick) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Double buffer: loads go to staging, display only changes at the commit point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging <= '0;
            display <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                staging <= in_frame;
            end
            if (commit) begin
                if (load) begin
                    display <= in_frame;
                end else if (pending) begin
                    display <= staging;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Frame-done pulse lands on the cycle after the commit point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= commit;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz;

    seg7_lzb_mask #(
        .DIGITS (DIGITS)
    ) u_lzb_mask (
        .data (display.data),
        .lz   (lz)
    );
`endif

    // Select the current slot's nibble, point and blank from the display buffer.
    always_comb begin
        hex_nxt   = display.data[4*digit_idx +: 4];
        point_nxt = display.point[digit_idx];
`ifdef LEADING_ZERO_BLANK_EN
        le_nxt    = display.le[digit_idx] | lz[digit_idx];
`else
        le_nxt    = display.le[digit_idx];
`endif
        an_nxt    = seg7_onecold(digit_idx);
    end

    // Registered decoder and digit-enable outputs, one clock behind digit_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an    <= '1;
            hex   <= 4'h0;
            point <= 1'b0;
            le    <= 1'b1;
        end else begin
            an    <= an_nxt;
            hex   <= hex_nxt;
            point <= point_nxt;
            le    <= le_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a 4-clock scan slot.
// The reference model works from elapsed clock edges since reset: slot and
// frame position come from plain division, and the visible frame is the last
// load made at or before the most recent frame boundary.
module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 2;
    localparam int SLOT     = 4;
    localparam int FRAME    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load = 1'b0;
    logic [31:0]       data_in = '0;
    logic [7:0]        point_in = '0;
    logic [7:0]        le_in = '0;
    logic [3:0]        hex;
    logic              point;
    logic              le;
    logic [7:0]        an;
    logic [IDX_W-1:0]  digit_idx;
    logic              frame_done;

    seg7_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .point_in   (point_in),
        .le_in      (le_in),
        .hex        (hex),
        .point      (point),
        .le         (le),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        seg7_frame_t f;
    } load_ev_t;

    load_ev_t loads[$];
    int       edge_n;
    int       last_fd;
    int       tests;
    int       fails;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif

    // Frame visible after n edges: last load at or before the latest boundary.
    function automatic seg7_frame_t shown_frame(input int n);
        seg7_frame_t r;
        int          c;
        r = '0;
        c = (n / FRAME) * FRAME;
        if (c == 0) return r;
        foreach (loads[i]) begin
            if (loads[i].edge_no <= c) r = loads[i].f;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_model();
        seg7_frame_t f;
        int          idx;
        logic [31:0] sh;
        logic [7:0]  e_an;
        logic [3:0]  e_hex;
        logic        e_point;
        logic        e_le;
        int          e_idx;
        logic        e_fd;
        if (edge_n == 0) begin
            e_an = 8'hFF; e_hex = 4'h0; e_point = 1'b0; e_le = 1'b1;
        end else begin
            idx     = ((edge_n - 1) / SLOT) % DIGITS;
            f       = shown_frame(edge_n - 1);
            sh      = f.data >> (4 * idx);
            e_an    = ~(8'd1 << idx);
            e_hex   = sh[3:0];
            e_point = f.point[idx];
            e_le    = f.le[idx];
            if (LZ_ON && idx != 0 && sh == 32'd0) e_le = 1'b1;
        end
        e_idx = (edge_n / SLOT) % DIGITS;
        e_fd  = (edge_n > 0) && (edge_n % FRAME == 0);
        chk("an", 32'(an), 32'(e_an));
        chk("hex", 32'(hex), 32'(e_hex));
        chk("point", 32'(point), 32'(e_point));
        chk("le", 32'(le), 32'(e_le));
        chk("digit_idx", 32'(digit_idx), 32'(e_idx));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        if (frame_done === 1'b1) begin
            if (last_fd > 0) chk("fd_interval", 32'(edge_n - last_fd), 32'd32);
            last_fd = edge_n;
        end
    endtask

    task automatic cycle(input bit ld, input logic [31:0] d, input logic [7:0] p, input logic [7:0] l);
        load_ev_t ev;
        load     = ld;
        data_in  = d;
        point_in = p;
        le_in    = l;
        @(posedge clk);
        edge_n++;
        if (ld) begin
            ev.edge_no = edge_n;
            ev.f       = seg7_frame_t'({d, p, l});
            loads.push_back(ev);
        end
        #1;
        load = 1'b0;
        check_model();
    endtask

    task automatic idle_to(input int target);
        while (edge_n < target) cycle(1'b0, $urandom, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        logic [31:0] rnd;
        logic [7:0]  rp;
        logic [7:0]  rl;
        bit          ld;
        int          stop;
        tests   = 0;
        fails   = 0;
        edge_n  = 0;
        last_fd = 0;

        // power-on reset
        #1 rst = 1'b1;
        #1 check_model();
        repeat (2) begin
            @(posedge clk);
            #1 check_model();
        end
        rst = 1'b0;
        check_model();

        // load then commit at edge 32
        idle_to(4);
        cycle(1'b1, 32'h1234ABCD, 8'h01, 8'h00);
        idle_to(33);
        chk("slot0_an", 32'(an), 32'hFE);
        chk("slot0_hex", 32'(hex), 32'hD);
        chk("slot0_point", 32'(point), 32'h1);
        idle_to(61);
        chk("slot7_an", 32'(an), 32'h7F);
        chk("slot7_hex", 32'(hex), 32'h1);
        chk("slot7_point", 32'(point), 32'h0);

        // mid-frame load in slot 3
        idle_to(77);
        cycle(1'b1, 32'h55555555, 8'($urandom), 8'h00);
        idle_to(90);
        chk("midload_old_hex", 32'(hex), 32'h2);
        idle_to(97);
        chk("midload_new_hex", 32'(hex), 32'h5);

        // load on the commit-point edge goes straight to the display
        rnd = $urandom;
        rp  = 8'($urandom);
        idle_to(127);
        cycle(1'b1, rnd, rp, 8'h00);
        chk("bypass_pending", 32'(dut.pending), 32'h0);
        idle_to(129);
        chk("bypass_hex", 32'(hex), 32'(rnd[3:0]));
        chk("bypass_point", 32'(point), 32'(rp[0]));

        // per-digit blank on digit 7
        idle_to(139);
        cycle(1'b1, 32'h87654321, 8'h00, 8'h80);
        idle_to(161);
        chk("blank_slot0_le", 32'(le), 32'h0);
        chk("blank_slot0_hex", 32'(hex), 32'h1);
        idle_to(189);
        chk("blank_slot7_le", 32'(le), 32'h1);

        // leading-zero cases
        idle_to(199);
        cycle(1'b1, 32'h000000A5, 8'h00, 8'h00);
        idle_to(229);
        chk("lz_a5_slot1_le", 32'(le), 32'h0);
        chk("lz_a5_slot1_hex", 32'(hex), 32'hA);
        idle_to(233);
        chk("lz_a5_slot2_le", 32'(le), 32'(LZ_ON));
        idle_to(239);
        cycle(1'b1, 32'h0, 8'h00, 8'h00);
        idle_to(257);
        chk("lz_zero_slot0_le", 32'(le), 32'h0);
        idle_to(261);
        chk("lz_zero_slot1_le", 32'(le), 32'(LZ_ON));

        // random loads, some on commit edges, varied leading zeros
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 9) == 0);
            if (((edge_n + 1) % FRAME == 0) && ($urandom_range(0, 1) == 1)) ld = 1'b1;
            rnd = $urandom >> (4 * $urandom_range(0, 8));
            rl  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cycle(ld, rnd, 8'($urandom), rl);
        end

        // reset mid-scan with a load still pending
        stop = edge_n + 13;
        idle_to(stop);
        cycle(1'b1, 32'hDEADBEEF, 8'hFF, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_le", 32'(le), 32'h1);
        chk("rst_digit_idx", 32'(digit_idx), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_pending", 32'(dut.pending), 32'h0);
        loads.delete();
        edge_n  = 0;
        last_fd = 0;
        check_model();
        @(posedge clk);
        #1 check_model();
        rst = 1'b0;
        idle_to(70);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
